// File: rtl/dm_responder.sv
// dm_responder: multi-cycle data-memory target for the CPU load/store path.
// One word request at a time is accepted over Req/Ack. The read or write is
// performed a fixed LATENCY edges after acceptance. Misaligned, out-of-range
// and read+write requests complete with Err=1 and MemReadData=0.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset (storage is not cleared)
//   Req           request valid, held by the initiator until Ack
//   MemRead       read qualifier
//   MemWrite      write qualifier
//   MemAddr       byte address (word index = MemAddr[31:2])
//   MemWriteData  store data
//   MemReadData   registered load data, held until next read/error/reset
//   Ack           one-cycle completion pulse
//   Err           request rejected, valid only while Ack=1
//   Busy          request in flight
module dm_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Req,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] MemAddr,
  input  logic [31:0] MemWriteData,
  output logic [31:0] MemReadData,
  output logic        Ack,
  output logic        Err,
  output logic        Busy
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] LIMIT    = 33'(4 * DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  logic [3:0]     cnt;
  logic [AW-1:0]  widx_q;
  logic [31:0]    wdata_q;
  logic           rd_q;
  logic           wr_q;
  logic           err_q;
  logic           req_err;
  logic           done;

  logic [31:0]    mem [DEPTH];

  // Error is decided at accept time so only the word index needs latching.
  always_comb begin
    req_err = 1'b0;
    if (MemAddr[1:0] != 2'b00)        req_err = 1'b1;
    if ({1'b0, MemAddr} >= LIMIT)     req_err = 1'b1;
    if (MemRead && MemWrite)          req_err = 1'b1;
  end

  assign done = (state == WAIT) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      widx_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      MemReadData <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Req) begin
            widx_q  <= MemAddr[AW+1:2];
            wdata_q <= MemWriteData;
            rd_q    <= MemRead;
            wr_q    <= MemWrite;
            err_q   <= req_err;
            cnt     <= CNT_INIT;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= RESP;
            if (err_q)     MemReadData <= '0;
            else if (rd_q) MemReadData <= mem[widx_q];
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage has no reset; a reset before the commit edge leaves state in
  // IDLE so the pending write never reaches the array.
  always_ff @(posedge clk) begin
    if (done && wr_q && !err_q) mem[widx_q] <= wdata_q;
  end

  assign Ack  = (state == RESP);
  assign Err  = (state == RESP) && err_q;
  assign Busy = (state != IDLE);

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Multi-cycle data-memory responder: the target side of the CPU load/store interface.
- Accepts one word request at a time over a Req/Ack handshake and performs a word read or write after a fixed, configurable latency.
- Flags misaligned, out-of-range and conflicting requests with Err.
- Sits between the CPU datapath (the initiator) and the data storage array; used when the processor moves from single-cycle to stalled or multi-cycle memory access.

Parameters:
- DEPTH, 256: number of 32-bit words stored; valid byte addresses are 0 .. 4*DEPTH-4.
- LATENCY, 2: edges from the accepting edge to the edge at which Ack rises; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- Req  input  1  request valid; held high by the initiator until Ack.
- MemRead  input  1  read request qualifier.
- MemWrite  input  1  write request qualifier.
- MemAddr  input  32  byte address; word index is MemAddr[31:2].
- MemWriteData  input  32  store data.
- MemReadData  output  32  load data, registered.
- Ack  output  1  one-cycle completion pulse.
- Err  output  1  valid only while Ack=1; request rejected.
- Busy  output  1  high while a request is in flight (state != IDLE).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, counter=0; Ack=0, Err=0, Busy=0, MemReadData=0.
  - Any pending write is discarded.
  - Storage array contents are NOT cleared.
- State machine: IDLE, WAIT, RESP. Outputs are Moore, decoded from registered state and flags.
- IDLE:
  - Busy=0, Ack=0.
  - At an edge with Req=1: latch MemAddr, MemWriteData, MemRead and MemWrite; compute the error flag; load counter=LATENCY-1; go to WAIT.
  - Req=0: stay in IDLE.
- WAIT:
  - Busy=1.
  - counter != 0: decrement.
  - counter == 0: go to RESP. At that same edge:
    - Successful write: commit the latched data to the word.
    - Successful read: load MemReadData.
    - Error: force MemReadData=0.
  - Input changes during WAIT are ignored, because all request fields are latched.
- RESP:
  - Ack=1, Busy=1, Err=latched error flag.
  - Next edge: go to IDLE unconditionally. Req is not sampled in RESP.
  - The initiator must drop Req during the Ack cycle. Req still high in the following IDLE cycle is a new request.
- Latency:
  - Accept at edge k; Ack is high from edge k+LATENCY to edge k+LATENCY+1.
  - Minimum spacing between accepts is LATENCY+2 edges.
- Error conditions (error flag set, no write, MemReadData=0):
  - MemAddr[1:0] != 0.
  - MemAddr >= 4*DEPTH, compared as 32-bit unsigned.
  - MemRead=1 and MemWrite=1 together.
- Req=1 with MemRead=0 and MemWrite=0:
  - Treated as a no-op; Ack with Err=0.
  - No write; MemReadData holds its previous value.
- MemReadData holds its last value until the next completing read, error, or reset.
- Reset asserted in WAIT or RESP:
  - Immediately returns to IDLE with Ack=0.
  - The write is not committed if reset arrives before the commit edge.
- Storage is an internal register array, word-addressed, with no byte enables.

Test Plan:
- LATENCY=2, write 0xDEADBEEF to 0x10 (Req high at edge 0) -> Busy=1 after edge 0; Ack=1, Err=0 exactly between edges 2 and 3; Busy=0 after edge 3.
- Read 0x10 after the previous write -> MemReadData=0xDEADBEEF appears with Ack; value held after Ack drops.
- Read 0x12 (misaligned), and separately read 0x400 with DEPTH=256 -> Ack with Err=1, MemReadData=0; a following read of 0x10 still returns 0xDEADBEEF.
- MemRead=1 and MemWrite=1 to 0x20 with data 0x5 -> Err=1; a subsequent read of 0x20 returns its prior value.
- Write 0x11111111 to 0x30, then assert rst_n=0 during WAIT, release, read 0x30 -> Ack=0 immediately on reset; read returns the pre-write value, not 0x11111111.
- LATENCY=1 back-to-back: write 0xA to 0x0, hold Req through RESP with new fields (read 0x0) -> second request accepted only in IDLE; Ack for the read rises 1 edge after its accept edge with MemReadData=0xA.
